camera_stream_generator: RTL and testbench
==========================================

// Module: camera_stream_generator
// PURPOSE
//   Synthesizable camera-side transmitter for the sobel/motion pipeline. Produces the
//   vsync/hsync edge pulses, validCamera strobe and 8-bit gray camData in the same framing
//   that sobelAccelerator consumes. Sources test patterns for bring-up, with no sensor needed.
//   Mode 2 scrolls one row per frame, so the motion-detection path sees real frame-to-frame change.
// PARAMETERS
//   PIXELS_PER_LINE  640  pixels (valid strobes) per line
//   LINES_PER_FRAME  480  lines per frame
//   VBLANK_CYCLES    50   idle cycles before the vsync pulse
//   FPORCH_CYCLES    50   idle cycles between the vsync pulse and the first pixel
//   HBLANK_CYCLES    20   idle cycles after each hsync pulse
// PORTS
//   clock        in   1   system clock (single domain; camClock is tied to it downstream)
//   reset        in   1   synchronous, active-low reset
//   enable       in   1   1 = stream frames; 0 = stop after the current frame
//   patternMode  in   2   0 const, 1 h-ramp, 2 v-scroll, 3 checker; sampled at vsync
//   constValue   in   8   pixel value for mode 0; sampled at vsync
//   vsync        out  1   one-cycle pulse at frame start
//   hsync        out  1   one-cycle pulse at end of each line
//   validCamera  out  1   one-cycle strobe per pixel
//   camData      out  8   pixel value, qualified by validCamera
//   frameCount   out  16  completed frames, wraps 0xFFFF->0
//   busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//   - All outputs are registered. Reset (reset==0 at posedge) forces state IDLE, all
//     counters 0 and all outputs 0. Reset wins over everything, including mid-line.
//   - FSM states: IDLE -> VBLANK -> VSYNC -> FPORCH -> ACTIVE -> HSYNC -> HBLANK.
//     * IDLE: outputs 0. If enable==1, go to VBLANK.
//     * VBLANK: lasts VBLANK_CYCLES cycles.
//     * VSYNC: lasts 1 cycle with vsync=1. Latches patternMode/constValue; x=0, y=0.
//     * FPORCH: lasts FPORCH_CYCLES cycles.
//     * ACTIVE: lasts 2*PIXELS_PER_LINE cycles, phase toggles each cycle.
//       - Phase 0: validCamera=1 and camData=pixel(x,y).
//       - Phase 1: validCamera=0 and camData holds its value; x increments.
//     * HSYNC: lasts 1 cycle with hsync=1; x=0.
//     * HBLANK: lasts HBLANK_CYCLES cycles.
//       - If y<LINES_PER_FRAME-1: y++, go to ACTIVE.
//       - Else: frameCount++ on the exit cycle; go to VBLANK if enable==1, else IDLE.
//   - Frame period = VBLANK+1+FPORCH+LINES*(2*PIXELS+1+HBLANK) cycles.
//   - The first vsync asserts VBLANK_CYCLES+1 edges after the edge that samples enable=1 in IDLE.
//   - Deasserting enable mid-frame never truncates: the current frame completes, then the FSM idles.
//   - Pattern and constValue changes mid-frame are ignored until the next VSYNC.
//   - Pixel values (x, y are line/pixel indices, arithmetic mod 256):
//     * mode 0: constValue
//     * mode 1: x[7:0]
//     * mode 2: (y + frameCount)[7:0]
//     * mode 3: (x[3]^y[3]) ? 8'hFF : 8'h00
//   - vsync, hsync and validCamera are mutually exclusive, never high in the same cycle.
//   - busy falls in the cycle the FSM enters IDLE.
// TESTING (bench params PIXELS=4, LINES=3, VBLANK=5, FPORCH=3, HBLANK=2 -> 42-cycle frame)
//   1. Reset held low 10 cycles with enable=1 -> all outputs 0, busy=0. Release -> first vsync 6 edges later.
//   2. Mode 1, one frame -> 12 validCamera strobes, camData 0,1,2,3 per line; 3 hsync pulses;
//      strobes 2 cycles apart.
//   3. Mode 2, enable held for 3 frames -> vsyncs exactly 42 cycles apart. Frame k, line y gives camData=(y+k).
//      frameCount goes 1,2,3.
//   4. enable dropped mid-line 1 of frame 0 -> lines 1 and 2 still complete. frameCount=1.
//      busy=0 and no further vsync.
//   5. Mode 0, constValue=0x5A, changed to 0x11 mid-frame -> all pixels 0x5A this frame, 0x11 next frame.
//   6. reset pulsed low during ACTIVE -> next cycle all outputs 0 and state IDLE. Restart yields a full frame.

Source files
------------

// File: rtl/camera_stream_generator.sv
// Camera-side test-pattern transmitter: emits vsync/hsync pulses, a validCamera strobe and
// 8-bit gray camData in the framing the sobel/motion pipeline expects. No sensor is needed.
// Ports: clock, reset (sync, active-low), enable, patternMode[1:0], constValue[7:0] in;
//        vsync, hsync, validCamera, camData[7:0], frameCount[15:0], busy out (all registered).
module camera_stream_generator #(
  parameter int PIXELS_PER_LINE = 640,
  parameter int LINES_PER_FRAME = 480,
  parameter int VBLANK_CYCLES   = 50,
  parameter int FPORCH_CYCLES   = 50,
  parameter int HBLANK_CYCLES   = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  patternMode,
  input  logic [7:0]  constValue,
  output logic        vsync,
  output logic        hsync,
  output logic        validCamera,
  output logic [7:0]  camData,
  output logic [15:0] frameCount,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VBLANK, ST_VSYNC, ST_FPORCH, ST_ACTIVE, ST_HSYNC, ST_HBLANK
  } state_t;

  localparam logic [15:0] X_LAST  = 16'(PIXELS_PER_LINE - 1);
  localparam logic [15:0] Y_LAST  = 16'(LINES_PER_FRAME - 1);
  localparam logic [15:0] VB_LAST = 16'(VBLANK_CYCLES - 1);
  localparam logic [15:0] FP_LAST = 16'(FPORCH_CYCLES - 1);
  localparam logic [15:0] HB_LAST = 16'(HBLANK_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] x;
  logic [15:0] y;
  logic        phase;
  logic [1:0]  mode_q;
  logic [7:0]  const_q;

  function automatic logic [7:0] pixel(input logic [1:0] m, input logic [7:0] c,
                                       input logic [15:0] px, input logic [15:0] py,
                                       input logic [15:0] fc);
    logic [7:0] v;
    case (m)
      2'd0:    v = c;
      2'd1:    v = px[7:0];
      2'd2:    v = py[7:0] + fc[7:0];
      default: v = (px[3] ^ py[3]) ? 8'hFF : 8'h00;
    endcase
    return v;
  endfunction

  // Outputs are decoded from the current state and registered, so every output trails the
  // state register by one cycle; busy is the exception and tracks the state exactly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      mode_q      <= '0;
      const_q     <= '0;
      vsync       <= 1'b0;
      hsync       <= 1'b0;
      validCamera <= 1'b0;
      camData     <= '0;
      frameCount  <= '0;
      busy        <= 1'b0;
    end else begin
      vsync       <= (state == ST_VSYNC);
      hsync       <= (state == ST_HSYNC);
      validCamera <= (state == ST_ACTIVE) && !phase;
      if (state == ST_ACTIVE && !phase)
        camData <= pixel(mode_q, const_q, x, y, frameCount);
      else if (state == ST_IDLE)
        camData <= '0;

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_VBLANK;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_VBLANK: begin
          if (cnt == VB_LAST) begin
            state <= ST_VSYNC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_VSYNC: begin
          // Pattern settings only change at frame boundaries.
          mode_q  <= patternMode;
          const_q <= constValue;
          x       <= '0;
          y       <= '0;
          cnt     <= '0;
          state   <= ST_FPORCH;
        end
        ST_FPORCH: begin
          if (cnt == FP_LAST) begin
            state <= ST_ACTIVE;
            phase <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_ACTIVE: begin
          phase <= ~phase;
          if (phase) begin
            x <= x + 16'd1;
            if (x == X_LAST) state <= ST_HSYNC;
          end
        end
        ST_HSYNC: begin
          x     <= '0;
          cnt   <= '0;
          state <= ST_HBLANK;
        end
        ST_HBLANK: begin
          if (cnt == HB_LAST) begin
            cnt <= '0;
            if (y != Y_LAST) begin
              y     <= y + 16'd1;
              phase <= 1'b0;
              state <= ST_ACTIVE;
            end else begin
              frameCount <= frameCount + 16'd1;
              if (enable) begin
                state <= ST_VBLANK;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_stream_generator.sv
// Directed bench for camera_stream_generator with a small 4x3 frame (42-cycle period).
module tb_camera_stream_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  patternMode;
  logic [7:0]  constValue;
  logic        vsync, hsync, validCamera, busy;
  logic [7:0]  camData;
  logic [15:0] frameCount;

  int vectors    = 0;
  int miscompares = 0;

  // Capture state, cleared by clear_capture.
  int          cap_n;
  int          hs_n;
  int          excl_bad = 0;
  int          vs_t[$];
  logic [15:0] vs_fc[$];
  int          pix_t[$];
  logic [7:0]  pix_d[$];

  camera_stream_generator #(
    .PIXELS_PER_LINE(4), .LINES_PER_FRAME(3), .VBLANK_CYCLES(5),
    .FPORCH_CYCLES(3), .HBLANK_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .patternMode(patternMode),
    .constValue(constValue), .vsync(vsync), .hsync(hsync), .validCamera(validCamera),
    .camData(camData), .frameCount(frameCount), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_capture();
    cap_n = 0;
    hs_n  = 0;
    vs_t.delete();
    vs_fc.delete();
    pix_t.delete();
    pix_d.delete();
  endtask

  task automatic run_capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (vsync) begin
        vs_t.push_back(cap_n);
        vs_fc.push_back(frameCount);
      end
      if (hsync) hs_n++;
      if (validCamera) begin
        pix_t.push_back(cap_n);
        pix_d.push_back(camData);
      end
      if (int'(vsync) + int'(hsync) + int'(validCamera) > 1) excl_bad++;
      cap_n++;
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_capture();
  endtask

  task automatic wait_strobes(input int n);
    int guard = 0;
    while (pix_d.size() < n && guard < 200) begin
      run_capture(1);
      guard++;
    end
    vectors++;
    if (pix_d.size() < n) begin
      miscompares++;
      $display("FAIL wait_strobes: got %0d strobes, required %0d", pix_d.size(), n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({vsync, hsync, validCamera} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s syncs: got %b, required 000", tag, {vsync, hsync, validCamera});
    end
    vectors++;
    if (camData !== 8'h00) begin
      miscompares++;
      $display("FAIL %s camData: got %h, required 00", tag, camData);
    end
    vectors++;
    if (frameCount !== 16'h0) begin
      miscompares++;
      $display("FAIL %s frameCount: got %0d, required 0", tag, frameCount);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy: got %b, required 0", tag, busy);
    end
  endtask

  task automatic check_ramp_frame(input string tag);
    vectors++;
    if (pix_d.size() != 12) begin
      miscompares++;
      $display("FAIL %s strobes: got %0d, required 12", tag, pix_d.size());
    end
    for (int i = 0; i < 12 && i < pix_d.size(); i++) begin
      vectors++;
      if (pix_d[i] !== 8'(i % 4)) begin
        miscompares++;
        $display("FAIL %s pix%0d: got %0d, required %0d", tag, i, pix_d[i], i % 4);
      end
    end
    vectors++;
    if (hs_n != 3) begin
      miscompares++;
      $display("FAIL %s hsync count: got %0d, required 3", tag, hs_n);
    end
    vectors++;
    if (frameCount !== 16'd1) begin
      miscompares++;
      $display("FAIL %s frameCount: got %0d, required 1", tag, frameCount);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    patternMode = 2'd0;
    constValue = 8'h00;
    repeat (10) tick();
    check_idle_outputs("reset_hold");
    reset = 1'b1;
    clear_capture();
    run_capture(8);
    vectors++;
    if (vs_t.size() < 1 || vs_t[0] != 6) begin
      miscompares++;
      $display("FAIL first_vsync: got edge %0d, required 6", vs_t.size() ? vs_t[0] : -1);
    end
  endtask

  task automatic test_hramp();
    do_reset();
    patternMode = 2'd1;
    enable = 1'b1;
    run_capture(1);
    enable = 1'b0;
    run_capture(60);
    check_ramp_frame("hramp");
    for (int i = 0; i + 1 < pix_t.size(); i++) begin
      if (i % 4 != 3) begin
        vectors++;
        if (pix_t[i+1] - pix_t[i] != 2) begin
          miscompares++;
          $display("FAIL hramp gap%0d: got %0d, required 2", i, pix_t[i+1] - pix_t[i]);
        end
      end
    end
    vectors++;
    if (vs_t.size() != 1) begin
      miscompares++;
      $display("FAIL hramp vsync count: got %0d, required 1", vs_t.size());
    end
  endtask

  task automatic test_vscroll();
    do_reset();
    patternMode = 2'd2;
    enable = 1'b1;
    run_capture(140);
    enable = 1'b0;
    vectors++;
    if (vs_t.size() < 4) begin
      miscompares++;
      $display("FAIL vscroll vsync count: got %0d, required 4", vs_t.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        vectors++;
        if (vs_t[k] - vs_t[k-1] != 42) begin
          miscompares++;
          $display("FAIL vscroll period%0d: got %0d, required 42", k, vs_t[k] - vs_t[k-1]);
        end
        vectors++;
        if (vs_fc[k] !== 16'(k)) begin
          miscompares++;
          $display("FAIL vscroll frameCount%0d: got %0d, required %0d", k, vs_fc[k], k);
        end
      end
    end
    vectors++;
    if (pix_d.size() < 36) begin
      miscompares++;
      $display("FAIL vscroll strobes: got %0d, required >=36", pix_d.size());
    end else begin
      for (int i = 0; i < 36; i++) begin
        vectors++;
        if (pix_d[i] !== 8'((i % 12) / 4 + i / 12)) begin
          miscompares++;
          $display("FAIL vscroll pix%0d: got %0d, required %0d", i, pix_d[i], (i % 12) / 4 + i / 12);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    patternMode = 2'd1;
    enable = 1'b1;
    wait_strobes(5);
    enable = 1'b0;
    run_capture(80);
    check_ramp_frame("drop");
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop busy: got %b, required 0", busy);
    end
    vectors++;
    if (vs_t.size() != 1) begin
      miscompares++;
      $display("FAIL drop vsync count: got %0d, required 1", vs_t.size());
    end
  endtask

  task automatic test_const_change();
    do_reset();
    patternMode = 2'd0;
    constValue = 8'h5A;
    enable = 1'b1;
    wait_strobes(3);
    constValue = 8'h11;
    run_capture(100);
    enable = 1'b0;
    vectors++;
    if (pix_d.size() < 24) begin
      miscompares++;
      $display("FAIL const strobes: got %0d, required >=24", pix_d.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        vectors++;
        if (pix_d[i] !== ((i < 12) ? 8'h5A : 8'h11)) begin
          miscompares++;
          $display("FAIL const pix%0d: got %h, required %h", i, pix_d[i], (i < 12) ? 8'h5A : 8'h11);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    patternMode = 2'd1;
    enable = 1'b1;
    wait_strobes(2);
    reset = 1'b0;
    tick();
    check_idle_outputs("mid_reset");
    reset = 1'b1;
    clear_capture();
    run_capture(1);
    enable = 1'b0;
    run_capture(60);
    check_ramp_frame("restart");
  endtask

  task automatic test_mutex();
    vectors++;
    if (excl_bad != 0) begin
      miscompares++;
      $display("FAIL mutex: got %0d overlapping cycles, required 0", excl_bad);
    end
  endtask

  initial begin
    test_reset();
    test_hramp();
    test_vscroll();
    test_enable_drop();
    test_const_change();
    test_reset_mid();
    test_mutex();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
